multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 98 +++++++++
 rtl/mc_output_decode.sv | 119 +++++++++++
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode/funct
// constants, ALUOp encodings (also consumed by the ALU control block),
// the controller state enum, mux-select encodings and the control word.
package mips_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0]) that the controller itself cares about
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALUOp encodings handed to ALU control
  localparam logic [2:0] ALUOP_R    = 3'b111;
  localparam logic [2:0] ALUOP_ADDI = 3'b110;
  localparam logic [2:0] ALUOP_ORI  = 3'b101;
  localparam logic [2:0] ALUOP_ANDI = 3'b011;
  localparam logic [2:0] ALUOP_LUI  = 3'b001;
  localparam logic [2:0] ALUOP_LW   = 3'b010;
  localparam logic [2:0] ALUOP_SW   = 3'b100;
  localparam logic [2:0] ALUOP_BEQ  = 3'b000;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG_A  = 2'b11;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_MEM   = 4'd7,
    WB_R     = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JUMP_REG = 4'd12,
    TRAP     = 4'd13
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  // ALUOp for the immediate-arithmetic group; ADDI is the fallback
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] res;
    case (op)
      OP_ORI:  res = ALUOP_ORI;
      OP_ANDI: res = ALUOP_ANDI;
      OP_LUI:  res = ALUOP_LUI;
      default: res = ALUOP_ADDI;
    endcase
    return res;
  endfunction

  // True for every opcode the controller sequences
  function automatic logic op_supported(input logic [5:0] op);
    logic res;
    case (op)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_ANDI, OP_LUI,
      OP_LW, OP_SW, OP_BEQ, OP_J: res = 1'b1;
      default:                    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: maps the controller state (plus zero / mem_ready
// where a state qualifies a strobe on them) to the datapath control word.
// Build option: MC_ILLEGAL_TRAP_EN -- when defined, unknown opcodes trap
// instead of completing as a NOP in DECODE.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Control word per state; anything a state does not name stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADDI;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_ALU;
        end else begin
          ctrl.ir_write  = 1'b0;
          ctrl.pc_write  = 1'b0;
        end
      end
      DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADDI;
`ifdef MC_ILLEGAL_TRAP_EN
        ctrl.instr_done = 1'b0;
`else
        // unknown opcode retires here as a NOP
        ctrl.instr_done = ~op_supported(opcode);
`endif
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_R;
      end
      WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (opcode == OP_SW) begin
          ctrl.alu_op = ALUOP_SW;
        end else begin
          ctrl.alu_op = ALUOP_LW;
        end
      end
      MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_BEQ;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      JUMP_REG: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_REG_A;
        ctrl.instr_done = 1'b1;
      end
      TRAP: begin
        ctrl = '0;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state logic and
// the optional memory-ready wait counter; the control word itself comes
// from mc_output_decode.
// Build option: MC_ILLEGAL_TRAP_EN -- unknown opcodes and memory timeouts
// go to a sticky TRAP state (illegal_op=1) instead of back to FETCH.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_READY_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam int CNT_W = (MEM_READY_TIMEOUT > 1) ? $clog2(MEM_READY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_READY_TIMEOUT - 1);

`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t BAD_OP_DEST  = TRAP;
  localparam state_t TIMEOUT_DEST = TRAP;
`else
  localparam state_t BAD_OP_DEST  = FETCH;
  localparam state_t TIMEOUT_DEST = FETCH;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             waiting_s;
  logic             timeout_s;
  ctrl_t            ctrl_s;
  ctrl_t            out_s;

  // Memory-wait states and the timeout condition
  always_comb begin
    waiting_s = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    if ((MEM_READY_TIMEOUT > 0) && waiting_s && !mem_ready && (wait_cnt_q == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (timeout_s) begin
          state_d = TIMEOUT_DEST;
        end else if (mem_ready) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR) begin
              state_d = JUMP_REG;
            end else begin
              state_d = EXEC_R;
            end
          end
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = EXEC_I;
          OP_LW, OP_SW:                     state_d = MEM_ADDR;
          OP_BEQ:                           state_d = BRANCH;
          OP_J:                             state_d = JUMP;
          default:                          state_d = BAD_OP_DEST;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      WB_R:     state_d = FETCH;
      EXEC_I:   state_d = WB_I;
      WB_I:     state_d = FETCH;
      MEM_ADDR: begin
        if (opcode == OP_SW) begin
          state_d = MEM_WR;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        if (timeout_s) begin
          state_d = TIMEOUT_DEST;
        end else if (mem_ready) begin
          state_d = WB_MEM;
        end else begin
          state_d = MEM_RD;
        end
      end
      WB_MEM:   state_d = FETCH;
      MEM_WR: begin
        if (timeout_s) begin
          state_d = TIMEOUT_DEST;
        end else if (mem_ready) begin
          state_d = FETCH;
        end else begin
          state_d = MEM_WR;
        end
      end
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      JUMP_REG: state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  // Wait counter: restarts on any state change (covers entry to the wait
  // states, including a timeout that lands back in FETCH)
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) || timeout_s) begin
      wait_cnt_d = '0;
    end else if ((MEM_READY_TIMEOUT > 0) && waiting_s && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Sticky illegal flag, set on the way into TRAP
  always_comb begin
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_d = illegal_q | (state_d == TRAP);
`else
    illegal_d = 1'b0;
`endif
  end

  // State, counter and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
    end
  end

  mc_output_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  // Everything is quiet while reset is held, so an abandoned instruction
  // cannot emit a last write strobe
  always_comb begin
    if (reset) begin
      out_s = '0;
    end else begin
      out_s = ctrl_s;
    end
  end

  assign mem_req    = out_s.mem_req;
  assign mem_write  = out_s.mem_write;
  assign iord       = out_s.iord;
  assign ir_write   = out_s.ir_write;
  assign pc_write   = out_s.pc_write;
  assign reg_write  = out_s.reg_write;
  assign reg_dst    = out_s.reg_dst;
  assign mem_to_reg = out_s.mem_to_reg;
  assign alu_src_a  = out_s.alu_src_a;
  assign alu_src_b  = out_s.alu_src_b;
  assign pc_source  = out_s.pc_source;
  assign alu_op     = out_s.alu_op;
  assign instr_done = out_s.instr_done;
  assign illegal_op = illegal_q & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words
// written out by hand for each instruction class.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [17:0] obs_s;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs_s = {mem_req, mem_write, iord, ir_write, pc_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
                  alu_op, instr_done, illegal_op};

  // Control word layout:
  // mreq mwr iord irw pcw rw rdst m2r srca | srcb | pcsrc | aluop | done ill
  function automatic logic [17:0] mk(input logic [8:0] strb, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic [2:0] aop,
                                     input logic done, input logic ill);
    return {strb, sb, ps, aop, done, ill};
  endfunction

  task automatic check_vec(input string tag, input logic [17:0] got, input logic [17:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive mem_ready for this cycle, sample at the falling edge, advance
  task automatic cyc(input string tag, input logic rdy, input logic [17:0] exp);
    mem_ready = rdy;
    @(negedge clk);
    check_vec(tag, obs_s, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  logic [17:0] W_ZERO, W_F_WAIT, W_F_RDY, W_DEC, W_DEC_NOP, W_EXR, W_WBR;
  logic [17:0] W_EXI_ORI, W_WBI, W_MA_LW, W_MA_SW, W_MRD, W_WBM, W_MWR_WAIT;
  logic [17:0] W_MWR_RDY, W_BR0, W_BR1, W_JMP, W_JR, W_TRAP;

  initial begin
    W_ZERO     = mk(9'b000000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    W_F_WAIT   = mk(9'b100000000, 2'b01, 2'b00, 3'b110, 1'b0, 1'b0);
    W_F_RDY    = mk(9'b100110000, 2'b01, 2'b00, 3'b110, 1'b0, 1'b0);
    W_DEC      = mk(9'b000000000, 2'b11, 2'b00, 3'b110, 1'b0, 1'b0);
    W_DEC_NOP  = mk(9'b000000000, 2'b11, 2'b00, 3'b110, 1'b1, 1'b0);
    W_EXR      = mk(9'b000000001, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0);
    W_WBR      = mk(9'b000001100, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    W_EXI_ORI  = mk(9'b000000001, 2'b10, 2'b00, 3'b101, 1'b0, 1'b0);
    W_WBI      = mk(9'b000001000, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    W_MA_LW    = mk(9'b000000001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
    W_MA_SW    = mk(9'b000000001, 2'b10, 2'b00, 3'b100, 1'b0, 1'b0);
    W_MRD      = mk(9'b101000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    W_WBM      = mk(9'b000001010, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    W_MWR_WAIT = mk(9'b111000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    W_MWR_RDY  = mk(9'b111000000, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    W_BR0      = mk(9'b000000001, 2'b00, 2'b01, 3'b000, 1'b1, 1'b0);
    W_BR1      = mk(9'b000010001, 2'b00, 2'b01, 3'b000, 1'b1, 1'b0);
    W_JMP      = mk(9'b000010000, 2'b00, 2'b10, 3'b000, 1'b1, 1'b0);
    W_JR       = mk(9'b000010000, 2'b00, 2'b11, 3'b000, 1'b1, 1'b0);
    W_TRAP     = mk(9'b000000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);

    reset = 1'b1;
    mem_ready = 1'b1;
    set_instr(6'b000000, 6'b100000, 1'b0);
    @(negedge clk);
    check_vec("reset_outputs", obs_s, W_ZERO);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // add: 4 cycles, one fetch stall first
    cyc("add.fetch_stall", 1'b0, W_F_WAIT);
    cyc("add.fetch",       1'b1, W_F_RDY);
    cyc("add.decode",      1'b1, W_DEC);
    cyc("add.exec_r",      1'b1, W_EXR);
    cyc("add.wb_r",        1'b1, W_WBR);

    // lw with two stalled MEM_RD cycles: 7 cycles
    set_instr(6'b100011, 6'b000000, 1'b0);
    cyc("lw.fetch",   1'b1, W_F_RDY);
    cyc("lw.decode",  1'b1, W_DEC);
    cyc("lw.mem_adr", 1'b1, W_MA_LW);
    cyc("lw.rd_w1",   1'b0, W_MRD);
    cyc("lw.rd_w2",   1'b0, W_MRD);
    cyc("lw.rd",      1'b1, W_MRD);
    cyc("lw.wb_mem",  1'b1, W_WBM);

    // beq not taken / taken
    set_instr(6'b000100, 6'b000000, 1'b0);
    cyc("beq0.fetch",  1'b1, W_F_RDY);
    cyc("beq0.decode", 1'b1, W_DEC);
    cyc("beq0.branch", 1'b1, W_BR0);
    set_instr(6'b000100, 6'b000000, 1'b1);
    cyc("beq1.fetch",  1'b1, W_F_RDY);
    cyc("beq1.decode", 1'b1, W_DEC);
    cyc("beq1.branch", 1'b1, W_BR1);

    // jr and j
    set_instr(6'b000000, 6'b001000, 1'b0);
    cyc("jr.fetch",  1'b1, W_F_RDY);
    cyc("jr.decode", 1'b1, W_DEC);
    cyc("jr.jump",   1'b1, W_JR);
    set_instr(6'b000010, 6'b000000, 1'b0);
    cyc("j.fetch",  1'b1, W_F_RDY);
    cyc("j.decode", 1'b1, W_DEC);
    cyc("j.jump",   1'b1, W_JMP);

    // ori
    set_instr(6'b001101, 6'b000000, 1'b0);
    cyc("ori.fetch",  1'b1, W_F_RDY);
    cyc("ori.decode", 1'b1, W_DEC);
    cyc("ori.exec_i", 1'b1, W_EXI_ORI);
    cyc("ori.wb_i",   1'b1, W_WBI);

    // sw with one stalled MEM_WR cycle
    set_instr(6'b101011, 6'b000000, 1'b0);
    cyc("sw.fetch",   1'b1, W_F_RDY);
    cyc("sw.decode",  1'b1, W_DEC);
    cyc("sw.mem_adr", 1'b1, W_MA_SW);
    cyc("sw.wr_wait", 1'b0, W_MWR_WAIT);
    cyc("sw.wr",      1'b1, W_MWR_RDY);

    // unsupported opcode 111111
    set_instr(6'b111111, 6'b000000, 1'b0);
    cyc("bad.fetch", 1'b1, W_F_RDY);
`ifdef MC_ILLEGAL_TRAP_EN
    cyc("bad.decode", 1'b1, W_DEC);
    cyc("bad.trap1",  1'b1, W_TRAP);
    cyc("bad.trap2",  1'b1, W_TRAP);
`else
    cyc("bad.decode_nop", 1'b1, W_DEC_NOP);
    cyc("bad.refetch",    1'b1, W_F_RDY);
`endif
    // reset pulse clears any trap
    reset = 1'b1;
    @(negedge clk);
    check_vec("reset_pulse", obs_s, W_ZERO);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // reset while MEM_WR is stalled
    set_instr(6'b101011, 6'b000000, 1'b0);
    cyc("swr.fetch",   1'b1, W_F_RDY);
    cyc("swr.decode",  1'b1, W_DEC);
    cyc("swr.mem_adr", 1'b1, W_MA_SW);
    cyc("swr.wr_wait", 1'b0, W_MWR_WAIT);
    reset = 1'b1;
    cyc("swr.reset_cycle", 1'b0, W_ZERO);
    reset = 1'b0;
    cyc("swr.back_fetch", 1'b0, W_F_WAIT);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
